console_output_device: RTL

Memory-mapped character console that sits on the core's data memory interface at the printf address window, downstream of the load/store path. Byte stores to the TX register are queued in a FIFO and drained through a valid/ready byte stream toward a host-side sink (simulation printer or UART serializer). A status register lets firmware poll fill level and detect dropped characters. Replaces ad-hoc address snooping with a synthesizable, flow-controlled device.

---
 rtl/console_output_device_if.sv | 60 ++++++
 rtl/console_output_device.sv | 130 +++++++++++++
 2 files changed

// File: rtl/console_output_device_if.sv
// -----------------------------------------------------------------------------
// console_output_device_if
//
// Groups the data-memory bus (request, store data, registered load response,
// window select) with the outbound byte stream (valid/ready) of the console.
//
//   master : load/store path and host-side byte sink (drives requests, tx_ready)
//   slave  : the console device (drives select, load response, tx byte stream)
//
// Signals:
//   data_memory_interface_enable      request valid this cycle
//   data_memory_interface_state       0 = READ, 1 = WRITE
//   data_memory_interface_address     byte address
//   data_memory_interface_frame_mask  byte lanes; bit3 = data[7:0]
//   data_memory_interface_write_data  store data
//   device_select                     request hits the device window
//   read_data / read_valid            registered load response
//   tx_data / tx_valid / tx_ready     byte stream toward the sink
// -----------------------------------------------------------------------------
interface console_output_device_if;
  logic        data_memory_interface_enable;
  logic        data_memory_interface_state;
  logic [31:0] data_memory_interface_address;
  logic [3:0]  data_memory_interface_frame_mask;
  logic [31:0] data_memory_interface_write_data;
  logic        device_select;
  logic [31:0] read_data;
  logic        read_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output data_memory_interface_enable,
    output data_memory_interface_state,
    output data_memory_interface_address,
    output data_memory_interface_frame_mask,
    output data_memory_interface_write_data,
    output tx_ready,
    input  device_select,
    input  read_data,
    input  read_valid,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  data_memory_interface_enable,
    input  data_memory_interface_state,
    input  data_memory_interface_address,
    input  data_memory_interface_frame_mask,
    input  data_memory_interface_write_data,
    input  tx_ready,
    output device_select,
    output read_data,
    output read_valid,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/console_output_device.sv
// -----------------------------------------------------------------------------
// console_output_device
//
// Memory-mapped character console. Byte stores to TXDATA are queued in a
// circular FIFO and drained through a valid/ready byte stream. STATUS exposes
// empty/full/overflow and the fill count; writing bit 2 of STATUS clears the
// sticky overflow flag.
//
// Register map (address[2]; address[1:0] ignored):
//   +0 TXDATA  write: push write_data[7:0] (lane 3 only); read: 0
//   +4 STATUS  read : [0] empty, [1] full, [2] overflow, [15:8] count
//              write: write_data[2]=1 clears overflow (lane 3 only)
//
// Ports:
//   clk       single clock, all state on posedge
//   reset     synchronous, active-high
//   bus       console_output_device_if.slave (memory bus + tx stream)
//   overflow  sticky: a byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module console_output_device #(
  parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
  parameter int          DEPTH        = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  console_output_device_if.slave       bus,
  output logic                         overflow
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic {
    REG_TXDATA = 1'b0,
    REG_STATUS = 1'b1
  } reg_sel_e;

  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic          fifo_empty;
  logic          fifo_full;
  reg_sel_e      reg_sel;
  logic          is_read;
  logic          push_req;
  logic          clear_req;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [31:0]   status_word;

  // Address bits below the register stride and unused data/lane bits.
  logic          unused_bits;
  assign unused_bits = ^{bus.data_memory_interface_address[1:0],
                         bus.data_memory_interface_frame_mask[2:0],
                         bus.data_memory_interface_write_data[31:8]};

  assign bus.device_select = bus.data_memory_interface_enable &&
      (bus.data_memory_interface_address[31:3] == BASE_ADDRESS[31:3]);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    reg_sel   = REG_TXDATA;
    is_read   = 1'b0;
    push_req  = 1'b0;
    clear_req = 1'b0;
    if (bus.data_memory_interface_address[2]) reg_sel = REG_STATUS;
    if (bus.device_select) begin
      if (!bus.data_memory_interface_state) begin
        is_read = 1'b1;
      end else if (bus.data_memory_interface_frame_mask[3]) begin
        push_req  = (reg_sel == REG_TXDATA);
        clear_req = (reg_sel == REG_STATUS) && bus.data_memory_interface_write_data[2];
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop     = !fifo_empty && bus.tx_ready;
  assign push_ok = push_req && (!fifo_full || pop);
  assign drop    = push_req && fifo_full && !pop;

  // STATUS samples pre-edge state, so a same-edge push/pop is not visible yet.
  assign status_word = {16'h0000, 8'(count), 5'b00000, overflow, fifo_full, fifo_empty};

  // Head byte is forced to zero while empty so stale storage never leaks out.
  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      bus.read_data  <= '0;
      bus.read_valid <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);

      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      // Set wins over a same-cycle clear.
      if (drop)           overflow <= 1'b1;
      else if (clear_req) overflow <= 1'b0;

      bus.read_valid <= is_read;
      bus.read_data  <= (is_read && reg_sel == REG_STATUS) ? status_word : 32'h0;
    end
  end

  // NOTE: storage is not reset; pointers and count define which entries are
  // live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.data_memory_interface_write_data[7:0];
  end

endmodule
